// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg
// Shared constants for the seven-segment digit driver:
//   - active-high segment font for hex digits 0-F, ordered {g,f,e,d,c,b,a}
//   - SEG_BLANK (all segments off, active-high)
//   - active-low anode codes for the four digits and the all-off code
//   - a helper that maps an anode pattern to a digit index plus a valid flag
package seven_seg_pkg;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_A     = 7'h77;
    localparam logic [6:0] SEG_B     = 7'h7C;
    localparam logic [6:0] SEG_C     = 7'h39;
    localparam logic [6:0] SEG_D     = 7'h5E;
    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_F     = 7'h71;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [3:0] AN_D0  = 4'b1110;
    localparam logic [3:0] AN_D1  = 4'b1101;
    localparam logic [3:0] AN_D2  = 4'b1011;
    localparam logic [3:0] AN_D3  = 4'b0111;
    localparam logic [3:0] AN_OFF = 4'b1111;

    typedef struct packed {
        logic       valid;
        logic [1:0] idx;
    } digit_sel_t;

    // Only the four one-hot-low codes select a digit; every other pattern
    // (no zero, several zeros) is reported as invalid.
    function automatic digit_sel_t anode_to_digit(input logic [3:0] an);
        digit_sel_t sel;
        sel.valid = 1'b1;
        sel.idx   = 2'd0;
        case (an)
            AN_D0:   sel.idx = 2'd0;
            AN_D1:   sel.idx = 2'd1;
            AN_D2:   sel.idx = 2'd2;
            AN_D3:   sel.idx = 2'd3;
            default: sel.valid = 1'b0;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/seven_seg_digit_driver_hex_to_seg.sv
// hex_to_seg
// Purely combinational hex font lookup. Output is active-high; the parent
// applies board polarity.
// Ports:
//   nibble  in  4  hex digit to display
//   font    out 7  segments {g,f,e,d,c,b,a}, 1 = segment lit
module hex_to_seg
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] font
);

    always_comb begin
        font = SEG_BLANK;
        case (nibble)
            4'h0: font = SEG_0;
            4'h1: font = SEG_1;
            4'h2: font = SEG_2;
            4'h3: font = SEG_3;
            4'h4: font = SEG_4;
            4'h5: font = SEG_5;
            4'h6: font = SEG_6;
            4'h7: font = SEG_7;
            4'h8: font = SEG_8;
            4'h9: font = SEG_9;
            4'hA: font = SEG_A;
            4'hB: font = SEG_B;
            4'hC: font = SEG_C;
            4'hD: font = SEG_D;
            4'hE: font = SEG_E;
            4'hF: font = SEG_F;
            default: font = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seven_seg_digit_driver.sv
// seven_seg_digit_driver
// Follows an external 4-digit anode scanner: picks the nibble of the
// displayed value belonging to the currently active digit, hex-decodes it and
// drives registered cathodes together with a registered copy of the anode.
// New values are staged and only committed when the scan enters digit 0, so a
// frame never shows a mix of old and new digits.
//
// Optional build macro: LEADING_ZERO_BLANK_EN
//   defined   - digits 3..1 go blank while they and all higher nibbles are 0
//   undefined - every digit always shows its hex value
//
// Parameters:
//   RESET_VALUE     value displayed from reset until the first commit
//   SEG_ACTIVE_LOW  1 = seg/dp low-true, 0 = high-true (an_out always low-true)
// Ports:
//   clock       in  1   system clock, rising edge
//   reset       in  1   asynchronous reset, active low
//   anode       in  4   scanner anode, active-low one-hot
//   value       in  16  display value, nibble i on digit i
//   dp_in       in  4   decimal point enables, 1 = lit
//   load        in  1   request to stage value
//   busy        out 1   a staged value is waiting for the next frame
//   load_ack    out 1   one-cycle pulse when the staged value commits
//   frame_tick  out 1   one-cycle pulse per frame boundary
//   an_out      out 4   registered anode, active low
//   seg         out 7   cathodes {g,f,e,d,c,b,a}
//   dp          out 1   decimal point cathode
module seven_seg_digit_driver
    import seven_seg_pkg::*;
#(
    parameter logic [15:0] RESET_VALUE    = 16'h0000,
    parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  anode,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    input  logic        load,
    output logic        busy,
    output logic        load_ack,
    output logic        frame_tick,
    output logic [3:0]  an_out,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? ~SEG_BLANK : SEG_BLANK;
    localparam logic       DP_OFF  = SEG_ACTIVE_LOW;

    logic [3:0]  anode_q;
    logic [3:0]  prev_q;
    logic [15:0] disp_reg;
    logic [15:0] stage_reg;

    digit_sel_t  sel;
    logic        boundary;
    logic        commit;
    logic [3:0]  nibble;
    logic [6:0]  font;
    logic        lz_blank;
    logic [6:0]  seg_hi;
    logic        dp_hi;

    // Boundary is the first cycle the synchronised anode shows digit 0.
    // An invalid pattern can never equal AN_D0, so it never creates one.
    assign sel      = anode_to_digit(anode_q);
    assign boundary = (anode_q == AN_D0) && (prev_q != AN_D0);
    assign commit   = boundary && busy;
    assign nibble   = disp_reg[{sel.idx, 2'b00} +: 4];

    hex_to_seg u_font (
        .nibble (nibble),
        .font   (font)
    );

`ifdef LEADING_ZERO_BLANK_EN
    // A digit is a leading zero when it and every nibble above it are zero;
    // digit 0 always shows so that a value of zero still reads "0".
    always_comb begin
        lz_blank = 1'b0;
        case (sel.idx)
            2'd1:    lz_blank = (disp_reg[15:4]  == 12'h000);
            2'd2:    lz_blank = (disp_reg[15:8]  == 8'h00);
            2'd3:    lz_blank = (disp_reg[15:12] == 4'h0);
            default: lz_blank = 1'b0;
        endcase
    end
`else
    assign lz_blank = 1'b0;
`endif

    // Active-high next-state for the cathodes; dp ignores leading-zero blanking.
    always_comb begin
        seg_hi = SEG_BLANK;
        dp_hi  = 1'b0;
        if (sel.valid) begin
            seg_hi = lz_blank ? SEG_BLANK : font;
            dp_hi  = dp_in[sel.idx];
        end
    end

    // Input synchronisation, staging/commit handshake and the output
    // registers. A load on a commit cycle still wins the stage register,
    // because the commit reads the old stage_reg before it is overwritten.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            anode_q    <= AN_OFF;
            prev_q     <= AN_OFF;
            disp_reg   <= RESET_VALUE;
            stage_reg  <= 16'h0000;
            busy       <= 1'b0;
            load_ack   <= 1'b0;
            frame_tick <= 1'b0;
            an_out     <= AN_OFF;
            seg        <= SEG_OFF;
            dp         <= DP_OFF;
        end else begin
            anode_q    <= anode;
            prev_q     <= anode_q;
            frame_tick <= boundary;
            load_ack   <= commit;

            if (commit) begin
                disp_reg <= stage_reg;
            end

            if (load) begin
                stage_reg <= value;
                busy      <= 1'b1;
            end else if (commit) begin
                busy <= 1'b0;
            end

            an_out <= sel.valid ? anode_q : AN_OFF;
            seg    <= SEG_ACTIVE_LOW ? ~seg_hi : seg_hi;
            dp     <= dp_hi ^ SEG_ACTIVE_LOW;
        end
    end

endmodule

// File: tb/tb_seven_seg_digit_driver.sv
// tb_seven_seg_digit_driver
// Drives a rotating anode scan with directed and random loads and compares
// every output each cycle against a reference model of the display rules.
// Macro LEADING_ZERO_BLANK_EN switches the expected leading-zero behaviour.
module tb_seven_seg_digit_driver;

    localparam int         HOLD = 4;
    localparam logic [6:0] OFF  = 7'b1111111;
    // Active-low hex font, {g,f,e,d,c,b,a}
    localparam logic [6:0] FONT_LO [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  anode = 4'b1111;
    logic [15:0] value = 16'h0000;
    logic [3:0]  dp_in = 4'h0;
    logic        load  = 1'b0;
    logic        busy;
    logic        load_ack;
    logic        frame_tick;
    logic [3:0]  an_out;
    logic [6:0]  seg;
    logic        dp;

    seven_seg_digit_driver #(
        .RESET_VALUE    (16'h0000),
        .SEG_ACTIVE_LOW (1'b1)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .anode      (anode),
        .value      (value),
        .dp_in      (dp_in),
        .load       (load),
        .busy       (busy),
        .load_ack   (load_ack),
        .frame_tick (frame_tick),
        .an_out     (an_out),
        .seg        (seg),
        .dp         (dp)
    );

    always #5 clock = ~clock;

    int          n_checks;
    int          n_fail;
    int          ack_count;
    int          tick_count;
    int          rot_idx;
    int          hold_cnt;
    int          a0;
    int          t0;
    logic [3:0]  cur_dp;
    logic [6:0]  seen_seg [4];

    // Reference model state: pin samples from the last two edges, the shown
    // value, and the pending staged value.
    logic [3:0]  h0;
    logic [3:0]  h1;
    logic [15:0] m_disp;
    logic [15:0] m_stage;
    logic        m_pending;
    logic [3:0]  exp_an;
    logic [6:0]  exp_seg;
    logic        exp_dp;
    logic        exp_busy;
    logic        exp_ack;
    logic        exp_tick;

    task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: observed %h, expected %h at %0t", tag, actual, expected, $time);
        end
    endtask

    function automatic int digit_of(input logic [3:0] a);
        int zeros;
        int pos;
        zeros = 0;
        pos   = -1;
        for (int i = 0; i < 4; i++) begin
            if (a[i] == 1'b0) begin
                zeros++;
                pos = i;
            end
        end
        return (zeros == 1) ? pos : -1;
    endfunction

    function automatic logic lz_blank(input int k, input logic [15:0] v);
        logic en;
`ifdef LEADING_ZERO_BLANK_EN
        en = 1'b1;
`else
        en = 1'b0;
`endif
        return en && (k != 0) && ((v >> (4 * k)) == 16'h0000);
    endfunction

    function automatic logic [3:0] an_code(input int i);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << i);
    endfunction

    task automatic model_reset();
        h0        = 4'b1111;
        h1        = 4'b1111;
        m_disp    = 16'h0000;
        m_stage   = 16'h0000;
        m_pending = 1'b0;
        exp_an    = 4'b1111;
        exp_seg   = OFF;
        exp_dp    = 1'b1;
        exp_busy  = 1'b0;
        exp_ack   = 1'b0;
        exp_tick  = 1'b0;
    endtask

    task automatic compareAll();
        checkOutput("an_out",     16'(an_out),     16'(exp_an));
        checkOutput("seg",        16'(seg),        16'(exp_seg));
        checkOutput("dp",         16'(dp),         16'(exp_dp));
        checkOutput("busy",       16'(busy),       16'(exp_busy));
        checkOutput("load_ack",   16'(load_ack),   16'(exp_ack));
        checkOutput("frame_tick", 16'(frame_tick), 16'(exp_tick));
    endtask

    task automatic clear_seen();
        for (int i = 0; i < 4; i++) seen_seg[i] = 7'h55;
    endtask

    // One clock: apply inputs, advance the model at the edge, compare at the
    // falling edge and record which glyph each digit last displayed.
    task automatic applyStimulus(input logic [3:0] an, input logic ld, input logic [15:0] val, input logic [3:0] dpv);
        int         k;
        int         ko;
        logic       bnd;
        logic [3:0] nib;
        anode = an;
        load  = ld;
        value = val;
        dp_in = dpv;
        @(posedge clock);
        bnd = (h0 == 4'b1110) && (h1 != 4'b1110);
        k   = digit_of(h0);
        if (k >= 0) begin
            nib     = m_disp[4*k +: 4];
            exp_an  = h0;
            exp_seg = lz_blank(k, m_disp) ? OFF : FONT_LO[nib];
            exp_dp  = ~dpv[k];
        end else begin
            exp_an  = 4'b1111;
            exp_seg = OFF;
            exp_dp  = 1'b1;
        end
        exp_tick = bnd;
        exp_ack  = bnd && m_pending;
        if (bnd && m_pending) begin
            m_disp    = m_stage;
            m_pending = 1'b0;
        end
        if (ld) begin
            m_stage   = val;
            m_pending = 1'b1;
        end
        exp_busy = m_pending;
        h1 = h0;
        h0 = an;
        @(negedge clock);
        compareAll();
        if (load_ack === 1'b1) ack_count++;
        if (frame_tick === 1'b1) tick_count++;
        ko = digit_of(an_out);
        if (ko >= 0) seen_seg[ko] = seg;
        load = 1'b0;
    endtask

    // Continue the scanner rotation for a number of cycles, optionally with
    // a load on the first of them.
    task automatic spin(input int cycles, input logic ld, input logic [15:0] val);
        for (int i = 0; i < cycles; i++) begin
            applyStimulus(an_code(rot_idx), ld && (i == 0), val, cur_dp);
            hold_cnt++;
            if (hold_cnt == HOLD) begin
                hold_cnt = 0;
                rot_idx  = (rot_idx + 1) % 4;
            end
        end
    endtask

    // Advance until the next rising edge is a frame-boundary commit edge.
    task automatic goto_boundary();
        logic found;
        found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            if ((h0 == 4'b1110) && (h1 != 4'b1110)) found = 1'b1;
            else spin(1, 1'b0, 16'h0000);
        end
        if (!found) begin
            $display("[TB] FAIL goto_boundary: observed no boundary, expected one within 64 cycles");
            $fatal(1, "[TB] scan rotation stalled");
        end
    endtask

    task automatic check_digits(input string tag, input logic [6:0] d3, input logic [6:0] d2,
                                input logic [6:0] d1, input logic [6:0] d0);
        checkOutput({tag, "_d3"}, 16'(seen_seg[3]), 16'(d3));
        checkOutput({tag, "_d2"}, 16'(seen_seg[2]), 16'(d2));
        checkOutput({tag, "_d1"}, 16'(seen_seg[1]), 16'(d1));
        checkOutput({tag, "_d0"}, 16'(seen_seg[0]), 16'(d0));
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        ack_count  = 0;
        tick_count = 0;
        rot_idx    = 0;
        hold_cnt   = 0;
        cur_dp     = 4'h0;
        clear_seen();
        model_reset();

        // Reset holds everything blank even with active-looking inputs.
        reset = 1'b0;
        anode = 4'b1110;
        load  = 1'b1;
        value = 16'hFFFF;
        repeat (3) @(negedge clock);
        compareAll();
        load  = 1'b0;
        reset = 1'b1;

        // Idle scan after reset: every digit reads "0".
        spin(32, 1'b0, 16'h0000);
        check_digits("reset_val", FONT_LO[0], FONT_LO[0], FONT_LO[0], FONT_LO[0]);

        // Mid-frame load commits once at the next boundary.
        spin(6, 1'b0, 16'h0000);
        spin(1, 1'b1, 16'h12AF);
        checkOutput("busy_after_load", 16'(busy), 16'h0001);
        a0 = ack_count;
        spin(40, 1'b0, 16'h0000);
        checkOutput("ack_12AF", 16'(ack_count - a0), 16'h0001);
        clear_seen();
        spin(16, 1'b0, 16'h0000);
        check_digits("v12AF", 7'b1111001, 7'b0100100, 7'b0001000, 7'b0001110);

        // Two loads in one frame: latest wins, single ack.
        goto_boundary();
        spin(3, 1'b0, 16'h0000);
        spin(1, 1'b1, 16'h1111);
        spin(1, 1'b0, 16'h0000);
        spin(1, 1'b1, 16'h2222);
        a0 = ack_count;
        spin(40, 1'b0, 16'h0000);
        checkOutput("ack_double_load", 16'(ack_count - a0), 16'h0001);
        clear_seen();
        spin(16, 1'b0, 16'h0000);
        check_digits("v2222", 7'b0100100, 7'b0100100, 7'b0100100, 7'b0100100);

        // Load on the commit edge while busy: 3333 commits, 4444 follows.
        goto_boundary();
        spin(3, 1'b0, 16'h0000);
        spin(1, 1'b1, 16'h3333);
        goto_boundary();
        a0 = ack_count;
        spin(1, 1'b1, 16'h4444);
        checkOutput("ack_coincident", 16'(load_ack), 16'h0001);
        checkOutput("busy_coincident", 16'(busy), 16'h0001);
        spin(20, 1'b0, 16'h0000);
        checkOutput("ack_pair", 16'(ack_count - a0), 16'h0002);
        clear_seen();
        spin(16, 1'b0, 16'h0000);
        check_digits("v4444", 7'b0011001, 7'b0011001, 7'b0011001, 7'b0011001);

        // Invalid anode patterns blank the display and never tick.
        goto_boundary();
        spin(6, 1'b0, 16'h0000);
        t0 = tick_count;
        for (int i = 0; i < 4; i++) applyStimulus(4'b1100, 1'b0, 16'h0000, 4'hF);
        checkOutput("an_invalid_1100", 16'(an_out), 16'h000F);
        checkOutput("seg_invalid_1100", 16'(seg), 16'(OFF));
        for (int i = 0; i < 4; i++) applyStimulus(4'b1111, 1'b0, 16'h0000, 4'hF);
        checkOutput("an_invalid_1111", 16'(an_out), 16'h000F);
        checkOutput("dp_invalid_1111", 16'(dp), 16'h0001);
        checkOutput("tick_invalid", 16'(tick_count - t0), 16'h0000);

        // Leading-zero behaviour.
        spin(1, 1'b1, 16'h0050);
        spin(40, 1'b0, 16'h0000);
        clear_seen();
        spin(16, 1'b0, 16'h0000);
`ifdef LEADING_ZERO_BLANK_EN
        check_digits("v0050", OFF, OFF, FONT_LO[5], FONT_LO[0]);
`else
        check_digits("v0050", FONT_LO[0], FONT_LO[0], FONT_LO[5], FONT_LO[0]);
`endif

        // Random loads, decimal points and occasional stray anode codes.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 7) == 0) cur_dp = 4'($urandom);
            if ($urandom_range(0, 31) == 0)
                applyStimulus(4'($urandom), 1'($urandom_range(0, 1)), 16'($urandom), cur_dp);
            else
                spin(1, ($urandom_range(0, 9) == 0), 16'($urandom));
        end

        // Reset mid-frame with a pending value: immediate blank, value lost.
        spin(1, 1'b1, 16'hBEEF);
        spin(2, 1'b0, 16'h0000);
        #2 reset = 1'b0;
        #1;
        model_reset();
        compareAll();
        @(negedge clock);
        reset = 1'b1;
        a0 = ack_count;
        spin(40, 1'b0, 16'h0000);
        checkOutput("ack_after_reset", 16'(ack_count - a0), 16'h0000);
        clear_seen();
        spin(16, 1'b0, 16'h0000);
        check_digits("after_reset", FONT_LO[0], FONT_LO[0], FONT_LO[0], FONT_LO[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seven_seg_digit_driver.md
Name: seven_seg_digit_driver

Overview:
- Downstream consumer of the 4-digit anode scanner. Takes the scanner's active-low one-hot anode and a 16-bit display value, selects the matching nibble, hex-decodes it and drives registered cathodes aligned with a registered anode copy.
- New values are staged in a shadow register and committed only at frame boundaries (entry to digit 0), so the display never tears mid-scan.

Parameters:
- RESET_VALUE, 16'h0000, value shown after reset until the first commit.
- SEG_ACTIVE_LOW, 1, 1 = seg/dp low-true (board default); 0 = high-true. an_out is always low-true.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- anode  in  4  scanner anode, active-low one-hot; rotation 1110 -> 1101 -> 1011 -> 0111; changes far slower than clock.
- value  in  16  display value; nibble i shown on digit i (digit 0 = rightmost).
- dp_in  in  4  decimal-point enables, bit i for digit i, 1 = lit.
- load  in  1  one-cycle request to stage value.
- busy  out  1  1 while a staged value awaits commit.
- load_ack  out  1  one-cycle pulse on the commit cycle.
- frame_tick  out  1  one-cycle pulse at each frame boundary.
- an_out  out  4  registered anode, active-low.
- seg  out  7  cathodes, order {g,f,e,d,c,b,a}.
- dp  out  1  decimal-point cathode.

Behaviour:
- Reset (async assert, sync-safe release): anode_q = 4'b1111, prev_q = 4'b1111, disp_reg = RESET_VALUE, stage_reg = 0, busy = 0, load_ack = 0, frame_tick = 0, an_out = 4'b1111, seg and dp blank (all-off at SEG_ACTIVE_LOW polarity).
- Input stage: anode_q <= anode and prev_q <= anode_q on every clock.
- Frame boundary: anode_q == 4'b1110 && prev_q != 4'b1110. On that edge frame_tick = 1 for exactly one cycle.
- Staging:
  - load with busy = 0: stage_reg <= value, busy <= 1.
  - load with busy = 1: stage_reg is overwritten (latest wins), busy stays 1, and no extra ack is generated.
- Commit: on a boundary cycle with busy = 1: disp_reg <= stage_reg, load_ack = 1 for one cycle, busy <= 0.
- Load on a boundary cycle:
  - If busy = 1: the old stage_reg commits first, then the new value is staged and busy stays 1.
  - If busy = 0: the new value is only staged and commits at the next boundary.
- Decode (registered, 1 clock after anode_q):
  - Valid patterns (exactly one zero bit) select nibble k of disp_reg and dp_in[k].
  - seg = standard hex font 0-F; dp lit iff dp_in[k].
  - an_out <= anode_q.
- Invalid anode_q (zero or >1 zero bits, incl. 1111): an_out <= 4'b1111, seg and dp blank, no boundary detected.
- Latency:
  - anode pin to an_out/seg: 2 clocks, with an_out and seg always updated on the same edge.
  - Boundary-cycle commit: disp_reg updates on that edge; the first segment using it appears 1 clock later.
- reset asserted mid-frame: immediate blank, busy cleared, and the pending value is lost.

Optional Feature:
- Macro LEADING_ZERO_BLANK_EN.
  - Defined: digit k (k = 3..1) shows blank seg when nibbles k..3 of disp_reg are all zero; digit 0 is never blanked. dp still follows dp_in, and an_out is unaffected.
  - Undefined: all four digits always show their hex value.

Decomposition:
- Package seven_seg_pkg holds:
  - segment-font localparams for 0-F and SEG_BLANK;
  - anode codes AN_D0..AN_D3 (1110, 1101, 1011, 0111) and AN_OFF (1111).
- Sub-module hex_to_seg: pure combinational 4-bit to 7-bit active-high font; polarity is applied in the parent.

Test Plan:
- Reset with RESET_VALUE = 16'h0000, then rotate anode → an_out follows 2 clocks later; seg = 7'b1000000 on every digit (active-low "0"); busy = 0.
- value = 16'h12AF with a load pulse mid-frame → busy = 1 until the next 0111 -> 1110 transition, then load_ack pulses once. Digits then read F, A, 2, 1 (seg 0001110, 0001000, 0100100, 1111001).
- Two loads in one frame (16'h1111 then 16'h2222) → single load_ack; every digit shows "2" (0100100).
- Load coincident with the boundary cycle while busy (staged 16'h3333, new 16'h4444) → 3333 commits now; 4444 commits at the following boundary with a second ack.
- Force anode = 4'b1100 or 4'b1111 → an_out = 1111 and seg blank 2 clocks later; frame_tick stays 0.
- With LEADING_ZERO_BLANK_EN and value 16'h0050: digits 3 and 2 blank, digit 1 = "5", digit 0 = "0". Without the macro, all four digits are lit.
